// File: rtl/fir_pkg.sv
// Shared types and elaboration helpers for the FIR tap delay line.
package fir_pkg;

  localparam int DWIDTH_DEF = 15;

  typedef logic signed [DWIDTH_DEF-1:0] sample_t;

  function automatic int buflen(input int ntaps, input int unr);
    return ntaps - 1 + unr;
  endfunction

  function automatic int nblk(input int ntaps, input int unr);
    return (buflen(ntaps, unr) + unr - 1) / unr;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fir_tapline_ctrl.sv
// Fill counter, primed flag and valid/ready handshake of the tap line.
module fir_tapline_ctrl
  import fir_pkg::*;
#(
  parameter int NBLK       = 10,
  parameter bit ZERO_PRIME = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic in_valid_i,
  input  logic taps_ready_i,
  output logic in_ready_o,
  output logic fire_o,
  output logic taps_valid_o,
  output logic primed_o
);

  localparam int CW = clog2(NBLK + 1);
  localparam logic [CW-1:0] FULL = CW'(NBLK);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          primed_q, primed_d;

  always_comb begin
    in_ready_o = !valid_q || taps_ready_i;
    fire_o     = in_valid_i && in_ready_o;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    if (fire_o) begin
      if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
      valid_d = ZERO_PRIME || (cnt_d == FULL);
    end else if (taps_ready_i) begin
      valid_d = 1'b0;
    end
    // A clear wins over a beat arriving in the same cycle
    if (clr_i) begin
      cnt_d   = '0;
      valid_d = 1'b0;
    end
    primed_d = (cnt_d == FULL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      primed_q <= primed_d;
    end
  end

  assign taps_valid_o = valid_q;
  assign primed_o     = primed_q;

endmodule

// File: rtl/fir_tapline.sv
// FIR input delay line: UNR samples in per beat, full tap window out.
module fir_tapline
  import fir_pkg::*;
#(
  parameter int DWIDTH     = 15,
  parameter int UNR        = 4,
  parameter int NTAPS      = 37,
  parameter bit ZERO_PRIME = 1'b0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DWIDTH-1:0] din  [UNR],
  output logic                     taps_valid,
  input  logic                     taps_ready,
  output logic signed [DWIDTH-1:0] dout [NTAPS+UNR-1],
  output logic                     primed
);

  localparam int BUFLEN = buflen(NTAPS, UNR);
  localparam int NBLK   = nblk(NTAPS, UNR);

  logic fire;

  fir_tapline_ctrl #(
    .NBLK      (NBLK),
    .ZERO_PRIME(ZERO_PRIME)
  ) u_ctrl (
    .clk_i       (CLK),
    .rst_i       (RST),
    .clr_i       (clr),
    .in_valid_i  (in_valid),
    .taps_ready_i(taps_ready),
    .in_ready_o  (in_ready),
    .fire_o      (fire),
    .taps_valid_o(taps_valid),
    .primed_o    (primed)
  );

  for (genvar i = 0; i < BUFLEN; i++) begin : g_tap
    logic signed [DWIDTH-1:0] src;
    logic signed [DWIDTH-1:0] tap_d, tap_q;

    if (i < UNR) begin : g_head
      assign src = din[i];
    end else begin : g_body
      assign src = dout[i-UNR];
    end

    always_comb begin
      tap_d = tap_q;
      if (clr) tap_d = '0;
      else if (fire) tap_d = src;
    end

    always_ff @(posedge CLK) begin
      if (RST) tap_q <= '0;
      else tap_q <= tap_d;
    end

    assign dout[i] = tap_q;
  end

endmodule

// File: tb/tb_fir_tapline.sv
// Scoreboard bench for fir_tapline: default, zero-prime and wide configs.
module tb_fir_tapline;
  import fir_pkg::*;

  typedef struct packed {
    logic              v;
    logic              p;
    logic [39:0][14:0] win;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic    rst = 1'b1, clr = 1'b0, iv = 1'b0, tr = 1'b0;
  logic    ir, tv, pr;
  sample_t din  [4];
  sample_t dout [40];

  fir_tapline u_dut (
    .CLK(clk), .RST(rst), .clr(clr),
    .in_valid(iv), .in_ready(ir), .din(din),
    .taps_valid(tv), .taps_ready(tr),
    .dout(dout), .primed(pr)
  );

  logic    z_rst = 1'b1, z_clr = 1'b0, z_iv = 1'b0, z_tr = 1'b0;
  logic    z_ir, z_tv, z_pr;
  sample_t z_din  [4];
  sample_t z_dout [40];

  fir_tapline #(.ZERO_PRIME(1'b1)) u_zp (
    .CLK(clk), .RST(z_rst), .clr(z_clr),
    .in_valid(z_iv), .in_ready(z_ir), .din(z_din),
    .taps_valid(z_tv), .taps_ready(z_tr),
    .dout(z_dout), .primed(z_pr)
  );

  logic              w_rst = 1'b1, w_clr = 1'b0, w_iv = 1'b0, w_tr = 1'b0;
  logic              w_ir, w_tv, w_pr;
  logic signed [15:0] w_din  [8];
  logic signed [15:0] w_dout [71];

  fir_tapline #(.DWIDTH(16), .UNR(8), .NTAPS(64)) u_wide (
    .CLK(clk), .RST(w_rst), .clr(w_clr),
    .in_valid(w_iv), .in_ready(w_ir), .din(w_din),
    .taps_valid(w_tv), .taps_ready(w_tr),
    .dout(w_dout), .primed(w_pr)
  );

  task automatic chk(input string tag,
                     input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  int   m_w [40];
  int   m_cnt = 0;
  bit   m_v = 1'b0;
  bit   m_known = 1'b0;
  int   sd [4];
  exp_t sb [$];

  task automatic step(input bit r, input bit c, input bit v, input bit t);
    exp_t e;
    bit   rdy, fire;
    rst = r; clr = c; iv = v; tr = t;
    for (int j = 0; j < 4; j++) din[j] = sample_t'(sd[j]);
    rdy  = !m_v || t;
    fire = v && rdy;
    #1;
    if (m_known) chk("in_ready", ir, rdy);
    if (r || c) begin
      for (int i = 0; i < 40; i++) m_w[i] = 0;
      m_cnt   = 0;
      m_v     = 1'b0;
      m_known = 1'b1;
    end else if (fire) begin
      for (int i = 39; i >= 4; i--) m_w[i] = m_w[i-4];
      for (int j = 0; j < 4; j++) m_w[j] = sd[j];
      if (m_cnt < 10) m_cnt++;
      m_v = (m_cnt == 10);
    end else if (t) begin
      m_v = 1'b0;
    end
    e.v = m_v;
    e.p = (m_cnt == 10);
    for (int i = 0; i < 40; i++) e.win[i] = 15'(m_w[i]);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("taps_valid", tv, e.v);
    chk("primed", pr, e.p);
    for (int i = 0; i < 40; i++)
      chk($sformatf("dout[%0d]", i), dout[i], $signed(e.win[i]));
  endtask

  task automatic beat(input int base);
    for (int j = 0; j < 4; j++) sd[j] = base + j;
    step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    for (int j = 0; j < 4; j++) begin
      sd[j]    = 0;
      z_din[j] = '0;
    end
    for (int j = 0; j < 8; j++) w_din[j] = '0;

    // reset held two cycles with a beat offered
    for (int j = 0; j < 4; j++) sd[j] = 55 + j;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    iv = 1'b0; rst = 1'b0; #1;
    chk("in_ready_after_rst", ir, 1'b1);

    for (int k = 1; k <= 10; k++) beat(10 * k);
    for (int j = 0; j < 4; j++) begin
      chk("prime_new", dout[j], 100 + j);
      chk("prime_old", dout[36+j], 10 + j);
    end
    chk("prime_tv", tv, 1'b1);
    beat(110);
    for (int j = 0; j < 4; j++) begin
      chk("b11_new", dout[j], 110 + j);
      chk("b11_old", dout[36+j], 20 + j);
    end

    for (int j = 0; j < 4; j++) sd[j] = 120 + j;
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_hold", dout[0], 110);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("bp_release", dout[0], 120);
    chk("bp_tv", tv, 1'b1);

    for (int j = 0; j < 4; j++) sd[j] = 7;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_tv", tv, 1'b0);
    chk("clr_dout0", dout[0], 0);
    for (int k = 1; k <= 9; k++) beat(200 + 10 * k);
    chk("reprime9_tv", tv, 1'b0);
    beat(300);
    chk("reprime10_tv", tv, 1'b1);

    for (int k = 0; k < 60; k++) begin
      for (int j = 0; j < 4; j++)
        sd[j] = (k % 7 == 0) ? -16384 : int'($urandom_range(32767)) - 16384;
      step(1'b0, $urandom_range(15) == 0,
           $urandom_range(3) != 0, $urandom_range(2) != 0);
    end

    for (int k = 1; k <= 10; k++) beat(-10 * k);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    z_rst = 1'b1;
    @(posedge clk); #1;
    z_rst = 1'b0; z_iv = 1'b1; z_tr = 1'b1;
    for (int j = 0; j < 4; j++) z_din[j] = sample_t'(j + 1);
    @(posedge clk); #1;
    z_iv = 1'b0;
    chk("zp_tv", z_tv, 1'b1);
    chk("zp_primed", z_pr, 1'b0);
    for (int i = 0; i < 4; i++) chk("zp_new", z_dout[i], i + 1);
    for (int i = 4; i < 40; i++) chk("zp_zero", z_dout[i], 0);

    w_rst = 1'b1;
    @(posedge clk); #1;
    w_rst = 1'b0; w_iv = 1'b1; w_tr = 1'b1;
    for (int j = 0; j < 8; j++) w_din[j] = 16'(-32768 + j);
    @(posedge clk); #1;
    chk("w_b1_tv", w_tv, 1'b0);
    for (int j = 0; j < 8; j++) w_din[j] = 16'(-32768);
    for (int k = 2; k <= 8; k++) begin
      @(posedge clk); #1;
    end
    chk("w_b8_tv", w_tv, 1'b0);
    chk("w_b8_primed", w_pr, 1'b0);
    @(posedge clk); #1;
    w_iv = 1'b0;
    chk("w_b9_tv", w_tv, 1'b1);
    chk("w_b9_primed", w_pr, 1'b1);
    chk("w_newest", w_dout[0], -32768);
    chk("w_row8", w_dout[63], -32768);
    for (int j = 0; j < 7; j++) chk("w_oldest_row", w_dout[64+j], -32768 + j);
    chk("w_tap70", w_dout[70], -32762);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
